// File: rtl/sentinel_pkg.sv
// Sentinel key conditioner shared definitions.
// Key width, default tuning and bounce counter helpers.
package sentinel_pkg;

   localparam int KEY_W             = 8;
   localparam int STABLE_CYCLES_DEF = 16;
   localparam int BOUNCE_WINDOW_DEF = 256;
   localparam int BOUNCE_LIMIT_DEF  = 8;
   localparam int BCNT_W            = 4;

   localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

   function automatic logic [BCNT_W-1:0] sat_inc(
      input logic [BCNT_W-1:0] v
   );
      return (v == BCNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sentinel_sync2.sv
// Two-flop level synchroniser for asynchronous inputs.
// Parameterised width, async active-low reset.
module sentinel_sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Plain flop chain, nothing between the stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sentinel_key_conditioner.sv
// Sentinel key conditioner: sync, whole-byte debounce,
// qualified key with strobe, and a bounce-rate alarm.
module sentinel_key_conditioner
   import sentinel_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int BOUNCE_WINDOW = BOUNCE_WINDOW_DEF,
   parameter int BOUNCE_LIMIT  = BOUNCE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [KEY_W-1:0]  sw_in,
   input  logic              clr_alarm,
   output logic [KEY_W-1:0]  key_out,
   output logic              key_valid,
   output logic              key_strobe,
   output logic              bounce_alarm,
   output logic [BCNT_W-1:0] bounce_count
);

   localparam int WW = $clog2(BOUNCE_WINDOW);
   localparam logic [7:0] CNT_TOP = 8'(STABLE_CYCLES - 1);
   localparam logic [BCNT_W-1:0] LIMIT = BCNT_W'(BOUNCE_LIMIT);

   logic [KEY_W-1:0]  raw_s;
   logic [KEY_W-1:0]  cand;
   logic [7:0]        cnt;
   logic [WW-1:0]     wcnt;
   logic              diff;
   logic              bev;
   logic              wrap;
   logic              hit;
   logic [BCNT_W-1:0] bcnt_next;

   sentinel_sync2 #(
      .W (KEY_W)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw_in),
      .q     (raw_s)
   );

   assign diff = (raw_s != cand);
   assign bev  = ena & diff;
   assign wrap = &wcnt;
   assign hit  = bev & (bcnt_next >= LIMIT);

   // Next bounce count: window wrap restarts the tally.
   always_comb begin
      bcnt_next = bounce_count;
      if (wrap) begin
         bcnt_next = {{(BCNT_W-1){1'b0}}, bev};
      end else if (bev) begin
         bcnt_next = sat_inc(bounce_count);
      end
   end

   // Candidate tracking and key qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand       <= '0;
         cnt        <= '0;
         key_out    <= '0;
         key_valid  <= 1'b0;
         key_strobe <= 1'b0;
      end else begin
         cand <= raw_s;
         if (!ena) begin
            cnt        <= '0;
            key_out    <= '0;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
         end else if (diff) begin
            cnt        <= '0;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
         end else if (cnt < CNT_TOP) begin
            cnt        <= cnt + 8'd1;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
         end else begin
            key_valid  <= 1'b1;
            key_out    <= cand;
            key_strobe <= (cand != key_out);
         end
      end
   end

   // Windowed bounce counter and sticky alarm.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt         <= '0;
         bounce_count <= '0;
         bounce_alarm <= 1'b0;
      end else begin
         if (ena) begin
            wcnt         <= wcnt + 1'b1;
            bounce_count <= bcnt_next;
         end
         if (hit) begin
            bounce_alarm <= 1'b1;
         end else if (clr_alarm) begin
            bounce_alarm <= 1'b0;
         end
      end
   end

endmodule
